// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              hold_flag_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_wen_o
);
  typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;
  localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};
  state_t state, state_n;
  logic [1:0] op;
  logic [DATA_W-1:0] quo, dvs, rem, res, quo_n, rem_n;
  logic [DATA_W:0] shl;
  logic [4:0] rd;
  logic [CNT_W-1:0] cnt;
  logic neg_q, neg_r, sgn, a_neg, b_neg, div0, ovf, ge, last;
  logic unused_op;
  assign unused_op = op_i[2];
  always_comb begin
    sgn   = ~op[0];
    a_neg = sgn & quo[DATA_W-1];
    b_neg = sgn & dvs[DATA_W-1];
    div0  = dvs == '0;
    ovf   = sgn && quo == MIN && dvs == '1;
    shl   = {rem, quo[DATA_W-1]};
    ge    = shl >= {1'b0, dvs};
    rem_n = ge ? DATA_W'(shl - {1'b0, dvs}) : shl[DATA_W-1:0];
    quo_n = {quo[DATA_W-2:0], ge};
    last  = cnt == CNT_W'(DATA_W-1);
    state_n = state;
    case (state)
      IDLE: state_n = (start_i && !flush_i) ? PREP : IDLE;
      PREP: state_n = flush_i ? IDLE : (div0 || ovf) ? DONE : CALC;
      CALC: state_n = flush_i ? IDLE : last ? DONE : CALC;
      DONE: state_n = IDLE;
    endcase
    busy_o      = state != IDLE;
    hold_flag_o = (state == IDLE && start_i) || state == PREP || state == CALC;
    ready_o     = state == DONE && !flush_i;
    rd_wen_o    = ready_o;
    result_o    = ready_o ? res : '0;
    rd_addr_o   = ready_o ? rd : '0;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= '0; quo <= '0; dvs <= '0; rem <= '0; res <= '0;
      rd <= '0; cnt <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i && !flush_i) begin
          op  <= op_i[1:0];
          quo <= dividend_i;
          dvs <= divisor_i;
          rd  <= rd_addr_i;
        end
        PREP: begin
          // special-case results are latched here; ignored when CALC follows
          res   <= div0 ? (op[1] ? quo : '1) : (op[1] ? '0 : MIN);
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          quo   <= a_neg ? -quo : quo;
          dvs   <= b_neg ? -dvs : dvs;
          rem   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
          if (last) res <= op[1] ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: table-driven and hand-sequenced checks of div_seq with a writeback scoreboard
module tb_div_seq;
  logic clk = 0, rst = 1, start_i = 0, flush_i = 0;
  logic [2:0] op_i = 0;
  logic [31:0] dividend_i = 0, divisor_i = 0;
  logic [4:0] rd_addr_i = 0;
  logic busy_o, hold_flag_o, ready_o, rd_wen_o;
  logic [31:0] result_o;
  logic [4:0] rd_addr_o;
  int n_vec = 0, n_err = 0, cyc = 0;

  typedef struct {logic [2:0] op; logic [31:0] a, b, exp; int lat;} vec_t;
  typedef struct {logic [31:0] res; logic [4:0] rd; int due;} exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  exp_t e;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .dividend_i(dividend_i),
    .divisor_i(divisor_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i), .busy_o(busy_o),
    .hold_flag_o(hold_flag_o), .ready_o(ready_o), .result_o(result_o),
    .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (op[0]) return op[1] ? a % b : a / b;
    return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  always @(negedge clk) begin
    #1;
    if (rd_wen_o) begin
      if (sb.size() == 0) chk("spurious_wb", {27'd0, rd_addr_o, result_o}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd_addr", rd_addr_o, e.rd);
        chk("latency", cyc, e.due);
        chk("ready_eq_wen", ready_o, 1);
      end
    end
  end

  task automatic drive(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    start_i = 1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
  endtask

  task automatic scramble();
    start_i = 0; op_i = 3'($urandom); dividend_i = $urandom; divisor_i = $urandom; rd_addr_i = 5'($urandom);
  endtask

  task automatic run(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                     logic [31:0] exp, int lat);
    int bad = 0;
    @(negedge clk);
    drive(op, a, b, rd);
    sb.push_back('{exp, rd, cyc + lat});
    #2 if (hold_flag_o !== 1) bad++;
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n == 1) scramble();
      #2 if (hold_flag_o !== (n < lat)) bad++;
    end
    chk("hold_pattern", bad, 0);
    chk("pending_wb", sb.size(), 0);
  endtask

  task automatic chk_quiet(string nm);
    chk(nm, {busy_o, hold_flag_o, ready_o, rd_wen_o, rd_addr_o, result_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    tbl.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 34});
    tbl.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 34});
    tbl.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34});
    tbl.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34});
    tbl.push_back('{3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34});
    tbl.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2});
    tbl.push_back('{3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2});
    tbl.push_back('{3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2});
    tbl.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
    tbl.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2});
    tbl.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34});
    tbl.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34});
    tbl.push_back('{3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34});
    tbl.push_back('{3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34});
    tbl.push_back('{3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34});
    tbl.push_back('{3'b000, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34});
    tbl.push_back('{3'b111, 32'd0, 32'd5, 32'd0, 34});
    repeat (3) @(negedge clk);
    #2 chk_quiet("reset_outputs");
    rst = 0;
    foreach (tbl[i]) run(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].exp, tbl[i].lat);
    for (int i = 0; i < 8; i++) begin
      rop = 3'(4 + $urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run(rop, ra, rb, 5'(20 + i), model(rop, ra, rb), 34);
    end

    // flush mid-CALC, then a fresh op two cycles later
    @(negedge clk); drive(3'b101, 32'd100, 32'd7, 5'd9);
    for (int n = 1; n <= 47; n++) begin
      @(negedge clk);
      if (n == 1) scramble();
      if (n == 10) flush_i = 1;
      if (n == 11) begin flush_i = 0; #2 chk("flush_hold", {busy_o, hold_flag_o}, 0); end
      if (n == 12) begin drive(3'b101, 32'd9, 32'd3, 5'd10); sb.push_back('{32'd3, 5'd10, cyc + 34}); end
      if (n == 13) scramble();
    end
    chk("flush_pending", sb.size(), 0);

    // start while busy and start in DONE are both ignored
    @(negedge clk); drive(3'b101, 32'd100, 32'd7, 5'd11); sb.push_back('{32'd14, 5'd11, cyc + 34});
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1 || n == 6 || n == 35) scramble();
      if (n == 5) drive(3'b101, 32'd1000, 32'd3, 5'd12);
      if (n == 34) drive(3'b101, 32'd50, 32'd5, 5'd13);
    end
    chk("busy_start_pending", sb.size(), 0);

    // reset mid-operation aborts with no writeback
    @(negedge clk); drive(3'b111, 32'd100, 32'd7, 5'd14);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) scramble();
      if (n == 20) rst = 1;
      if (n == 21) begin rst = 0; #2 chk_quiet("rst_mid_op"); end
    end

    // flush in DONE suppresses writeback; flush in IDLE drops start
    @(negedge clk); drive(3'b101, 32'd5, 32'd0, 5'd15);
    @(negedge clk); scramble();
    @(negedge clk); flush_i = 1; #2 chk("flush_done_ready", {ready_o, rd_wen_o}, 0);
    @(negedge clk); flush_i = 0;
    @(negedge clk); drive(3'b101, 32'd8, 32'd2, 5'd16); flush_i = 1;
    @(negedge clk); scramble(); flush_i = 0; #2 chk("flush_idle_busy", busy_o, 0);
    repeat (3) @(negedge clk);

    run(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFD, 34);
    repeat (2) @(negedge clk);
    chk("final_pending", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
